audio_frame_scheduler: RTL and testbench

Per-frame sample scheduler and mixer for the synthesizer's I2S output path. It generates the audio frame tick (i_Clk / DIVISOR) and polls each voice generator in fixed order through a one-hot request / valid handshake on a shared return bus. It sums the voices' signed stereo samples with saturation and holds the mixed left/right words stable for the I2S transmitter until the next frame. Missing or late voices are covered by per-voice timeout and overrun reporting.

---
 rtl/audio_frame_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_audio_frame_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_scheduler.sv
// audio_frame_scheduler
//
// Generates the audio frame tick and, once per frame, polls each voice generator
// in fixed order over a shared return bus. The signed stereo samples are summed in
// wide accumulators, saturated to SAMPLE_BITS and held on o_Left/o_Right for the
// I2S transmitter until the next frame is latched.
//
// Ports
//   i_Clk          system clock (sole domain)
//   i_Reset        synchronous, active-high reset
//   i_Mute         forces the latched mix to zero when high in the latch cycle
//   o_Voice_Req    one-hot poll request, bit k selects voice k
//   i_Voice_Valid  requested voice presents its sample this cycle
//   i_Voice_Left   signed left sample from the requested voice
//   i_Voice_Right  signed right sample from the requested voice
//   o_Left         mixed, saturated left sample
//   o_Right        mixed, saturated right sample
//   o_Frame_Tick   one-cycle pulse at each frame boundary
//   o_Frame_Valid  one-cycle pulse when o_Left/o_Right update
//   o_Timeout      one-cycle pulse when a voice is skipped
//   o_Overrun      one-cycle pulse when a tick lands while collection is busy

module audio_frame_scheduler #(
  parameter int unsigned DIVISOR     = 520,
  parameter int unsigned NUM_VOICES  = 4,
  parameter int unsigned SAMPLE_BITS = 16,
  parameter int unsigned TIMEOUT     = 8
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Mute,
  output logic [NUM_VOICES-1:0]  o_Voice_Req,
  input  logic                   i_Voice_Valid,
  input  logic [SAMPLE_BITS-1:0] i_Voice_Left,
  input  logic [SAMPLE_BITS-1:0] i_Voice_Right,
  output logic [SAMPLE_BITS-1:0] o_Left,
  output logic [SAMPLE_BITS-1:0] o_Right,
  output logic                   o_Frame_Tick,
  output logic                   o_Frame_Valid,
  output logic                   o_Timeout,
  output logic                   o_Overrun
);

  localparam int unsigned AccW  = SAMPLE_BITS + $clog2(NUM_VOICES) + 1;
  localparam int unsigned CntW  = $clog2(DIVISOR);
  localparam int unsigned IdxW  = $clog2(NUM_VOICES);
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  localparam logic signed [AccW-1:0] SatMax =
      {{(AccW - SAMPLE_BITS + 1){1'b0}}, {(SAMPLE_BITS - 1){1'b1}}};
  localparam logic signed [AccW-1:0] SatMin =
      {{(AccW - SAMPLE_BITS + 1){1'b1}}, {(SAMPLE_BITS - 1){1'b0}}};
  localparam logic [NUM_VOICES-1:0] ReqOne = {{(NUM_VOICES - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StLatch
  } state_e;

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic [IdxW-1:0]         idx_q;
  logic [WaitW-1:0]        wait_q;
  logic [NUM_VOICES-1:0]   req_q;
  logic signed [AccW-1:0]  acc_l_q, acc_r_q;
  logic signed [AccW-1:0]  acc_l_d, acc_r_d;
  // After a skip the request drops for one cycle (the o_Timeout cycle) before the
  // next voice is polled, so every skipped voice costs exactly TIMEOUT extra cycles.
  logic                    bubble_q;
  logic                    skip_done_q;
  logic [SAMPLE_BITS-1:0]  left_q, right_q;
  logic                    frame_valid_q, timeout_q, overrun_q;

  logic                    frame_tick;
  logic                    last_voice;
  logic [SAMPLE_BITS-1:0]  sat_l, sat_r;

  function automatic logic [SAMPLE_BITS-1:0] saturate(input logic signed [AccW-1:0] acc);
    if (acc > SatMax) begin
      return {1'b0, {(SAMPLE_BITS - 1){1'b1}}};
    end else if (acc < SatMin) begin
      return {1'b1, {(SAMPLE_BITS - 1){1'b0}}};
    end
    return acc[SAMPLE_BITS-1:0];
  endfunction

  assign frame_tick = (cnt_q == CntW'(DIVISOR - 1));
  assign last_voice = (idx_q == IdxW'(NUM_VOICES - 1));

  always_comb begin
    acc_l_d = acc_l_q + {{(AccW - SAMPLE_BITS){i_Voice_Left[SAMPLE_BITS-1]}}, i_Voice_Left};
    acc_r_d = acc_r_q + {{(AccW - SAMPLE_BITS){i_Voice_Right[SAMPLE_BITS-1]}}, i_Voice_Right};
    sat_l   = saturate(acc_l_q);
    sat_r   = saturate(acc_r_q);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      idx_q         <= '0;
      wait_q        <= '0;
      req_q         <= '0;
      acc_l_q       <= '0;
      acc_r_q       <= '0;
      bubble_q      <= 1'b0;
      skip_done_q   <= 1'b0;
      left_q        <= '0;
      right_q       <= '0;
      frame_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      // The frame counter free-runs; overruns never disturb it.
      cnt_q         <= frame_tick ? '0 : cnt_q + CntW'(1);
      frame_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      overrun_q     <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (frame_tick) begin
            state_q     <= StReq;
            req_q       <= ReqOne;
            idx_q       <= '0;
            wait_q      <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            bubble_q    <= 1'b0;
            skip_done_q <= 1'b0;
          end
        end

        StReq: begin
          if (frame_tick) begin
            overrun_q <= 1'b1;
          end
          if (bubble_q) begin
            bubble_q <= 1'b0;
            if (skip_done_q) begin
              state_q <= StLatch;
            end else begin
              req_q <= ReqOne << idx_q;
            end
          end else if (i_Voice_Valid) begin
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
            wait_q  <= '0;
            if (last_voice) begin
              state_q <= StLatch;
              req_q   <= '0;
            end else begin
              idx_q <= idx_q + IdxW'(1);
              req_q <= req_q << 1;
            end
          end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
            // Skip: the voice contributes nothing to the mix.
            timeout_q   <= 1'b1;
            wait_q      <= '0;
            req_q       <= '0;
            bubble_q    <= 1'b1;
            skip_done_q <= last_voice;
            if (!last_voice) begin
              idx_q <= idx_q + IdxW'(1);
            end
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end

        StLatch: begin
          if (frame_tick) begin
            overrun_q <= 1'b1;
          end
          left_q        <= i_Mute ? '0 : sat_l;
          right_q       <= i_Mute ? '0 : sat_r;
          frame_valid_q <= 1'b1;
          state_q       <= StIdle;
        end

        default: begin
          state_q <= StIdle;
          req_q   <= '0;
        end
      endcase
    end
  end

  assign o_Voice_Req   = req_q;
  assign o_Left        = left_q;
  assign o_Right       = right_q;
  assign o_Frame_Tick  = frame_tick;
  assign o_Frame_Valid = frame_valid_q;
  assign o_Timeout     = timeout_q;
  assign o_Overrun     = overrun_q;

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// Scoreboard bench for audio_frame_scheduler. Each frame is described by a plan
// (per-voice response delay and samples); a reference model turns the plan into
// the expected mix, completion cycle, timeout and overrun counts.

module tb_audio_frame_scheduler;

  localparam int DIV = 32;
  localparam int NV  = 4;
  localparam int SB  = 16;
  localparam int TO  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mute = 1'b0;
  logic          vvalid = 1'b0;
  logic [SB-1:0] vl = '0;
  logic [SB-1:0] vr = '0;
  logic [NV-1:0] req;
  logic [SB-1:0] out_l, out_r;
  logic          tick, fvalid, tout, ovr;

  audio_frame_scheduler #(
    .DIVISOR    (DIV),
    .NUM_VOICES (NV),
    .SAMPLE_BITS(SB),
    .TIMEOUT    (TO)
  ) dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_Mute       (mute),
    .o_Voice_Req  (req),
    .i_Voice_Valid(vvalid),
    .i_Voice_Left (vl),
    .i_Voice_Right(vr),
    .o_Left       (out_l),
    .o_Right      (out_r),
    .o_Frame_Tick (tick),
    .o_Frame_Valid(fvalid),
    .o_Timeout    (tout),
    .o_Overrun    (ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int left;
    int right;
    int vcycle;
    int touts;
    int ovrs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  // Delay >= TO means the voice never answers.
  int   plan_d[NV];
  int   plan_l[NV];
  int   plan_r[NV];
  bit   mon_hold = 1'b1;

  task automatic check(input string name, input int act, input int req_v);
    checks++;
    if (act != req_v) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic set_voice(input int k, input int d, input int l, input int r);
    plan_d[k] = d;
    plan_l[k] = l;
    plan_r[k] = r;
  endtask

  task automatic wait_tick(output int t);
    int n = 0;
    while (!tick && n < 3 * DIV) begin
      @(negedge clk);
      n++;
    end
    check("tick_arrives", int'(tick), 1);
    t = cyc;
  endtask

  // Counts cycles from reset release up to the first tick.
  task automatic count_to_tick(input string name);
    int n = 0;
    int fv = 0;
    while (!tick && n < 3 * DIV) begin
      @(negedge clk);
      n++;
      fv += int'(fvalid);
    end
    check(name, n, DIV - 1);
    check({name, "_no_frame_valid"}, fv, 0);
  endtask

  task automatic run_frame(input bit m, input bit chk_req);
    int   t, lat, sl, sr, nto, j;
    exp_t e;
    mute = m;
    wait_tick(t);
    sl = 0;
    sr = 0;
    nto = 0;
    lat = t + 1;
    for (int k = 0; k < NV; k++) begin
      if (plan_d[k] < TO) begin
        sl += plan_l[k];
        sr += plan_r[k];
        lat += plan_d[k] + 1;
      end else begin
        nto++;
        lat += TO + 1;
      end
    end
    e.left   = m ? 0 : sat(sl);
    e.right  = m ? 0 : sat(sr);
    e.vcycle = lat + 1;
    e.touts  = nto;
    e.ovrs   = 0;
    j = 1;
    while (t + j * DIV <= lat) begin
      e.ovrs++;
      j++;
    end
    sb.push_back(e);
    if (chk_req) begin
      for (int k = 0; k < NV; k++) begin
        @(negedge clk);
        check($sformatf("req_seq_%0d", k), int'(req), 1 << k);
      end
    end
    while (cyc < lat + 1) @(negedge clk);
  endtask

  // Voice generators: answer the request after the planned delay; drive junk with
  // random valid while nothing is requested.
  initial begin
    logic [NV-1:0] prev;
    int            w, k;
    prev = '0;
    w = 0;
    forever begin
      @(negedge clk);
      if (req != '0 && req == prev) w++;
      else w = 0;
      prev = req;
      k = 0;
      for (int i = 0; i < NV; i++) if (req[i]) k = i;
      if (req != '0 && plan_d[k] < TO && w == plan_d[k]) begin
        vvalid = 1'b1;
        vl = SB'(plan_l[k]);
        vr = SB'(plan_r[k]);
      end else begin
        vvalid = (req == '0) ? 1'($urandom_range(0, 1)) : 1'b0;
        vl = SB'($urandom);
        vr = SB'($urandom);
      end
    end
  end

  // Monitor: pops the scoreboard on every o_Frame_Valid.
  initial begin
    int            tc, oc;
    logic [SB-1:0] lastl, lastr;
    exp_t          e;
    tc = 0;
    oc = 0;
    lastl = '0;
    lastr = '0;
    forever begin
      @(negedge clk);
      if (mon_hold) begin
        tc = 0;
        oc = 0;
      end else begin
        if (req != '0) check("req_onehot", int'($onehot(req)), 1);
        tc += int'(tout);
        oc += int'(ovr);
        if (fvalid) begin
          check("frame_valid_expected", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("left", int'($signed(out_l)), e.left);
            check("right", int'($signed(out_r)), e.right);
            check("valid_cycle", cyc, e.vcycle);
            check("timeouts", tc, e.touts);
            check("overruns", oc, e.ovrs);
          end
          tc = 0;
          oc = 0;
        end else begin
          check("left_stable", int'(out_l), int'(lastl));
          check("right_stable", int'(out_r), int'(lastr));
        end
      end
      lastl = out_l;
      lastr = out_r;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r, t;
    for (int k = 0; k < NV; k++) set_voice(k, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", int'(req), 0);
    check("rst_left", int'(out_l), 0);
    check("rst_right", int'(out_r), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_valid", int'(fvalid), 0);
    check("rst_timeout", int'(tout), 0);
    check("rst_overrun", int'(ovr), 0);
    rst = 1'b0;
    count_to_tick("first_tick");
    mon_hold = 1'b0;

    for (int k = 0; k < NV; k++) set_voice(k, 0, 1000, 1000);
    run_frame(1'b0, 1'b1);

    set_voice(0, 0, 30000, 100);
    set_voice(1, 0, 30000, -300);
    set_voice(2, 0, -5, 0);
    set_voice(3, 0, 0, 0);
    run_frame(1'b0, 1'b0);

    set_voice(0, 0, -30000, 7);
    set_voice(1, 1, -30000, -9);
    set_voice(2, 0, 0, 0);
    set_voice(3, 0, 0, 0);
    run_frame(1'b0, 1'b0);

    for (int k = 0; k < NV; k++) set_voice(k, 0, 500, 500);
    set_voice(2, TO, 9999, 9999);
    run_frame(1'b0, 1'b0);

    for (int k = 0; k < NV; k++) set_voice(k, TO, 1234, 1234);
    run_frame(1'b0, 1'b0);

    for (int k = 0; k < NV; k++) set_voice(k, 0, 700 + k, -300 - k);
    run_frame(1'b1, 1'b0);
    run_frame(1'b0, 1'b0);

    for (int f = 0; f < 30; f++) begin
      for (int k = 0; k < NV; k++) begin
        r = $urandom_range(0, 9);
        if (r < 6) plan_d[k] = $urandom_range(0, 1);
        else if (r < 8) plan_d[k] = $urandom_range(2, TO - 1);
        else plan_d[k] = TO;
        if ($urandom_range(0, 1) == 1) begin
          plan_l[k] = int'($urandom_range(0, 65535)) - 32768;
          plan_r[k] = int'($urandom_range(0, 65535)) - 32768;
        end else begin
          plan_l[k] = int'($urandom_range(0, 2000)) - 1000;
          plan_r[k] = int'($urandom_range(0, 2000)) - 1000;
        end
      end
      run_frame($urandom_range(0, 4) == 0, 1'b0);
    end

    // Known nonzero outputs so the reset clearing them is observable.
    for (int k = 0; k < NV; k++) set_voice(k, 0, 111, -222);
    run_frame(1'b0, 1'b0);
    set_voice(2, 3, 50, 50);
    wait_tick(t);
    n = 0;
    while (req != 4'b0100 && n < 4 * DIV) begin
      @(negedge clk);
      n++;
    end
    check("reset_req_0100_seen", int'(req), 4);
    mon_hold = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_req", int'(req), 0);
    check("midrst_left", int'(out_l), 0);
    check("midrst_right", int'(out_r), 0);
    check("midrst_valid", int'(fvalid), 0);
    rst = 1'b0;
    count_to_tick("tick_after_midrst");
    mon_hold = 1'b0;
    for (int k = 0; k < NV; k++) set_voice(k, 0, -4000, 4000);
    run_frame(1'b0, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 3 * DIV) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
